hazard_sched: RTL
=================

HAZARD_SCHED -- requirements
Module: hazard_sched

Interface
- REQ-001 The block SHALL have parameter TIMEOUT, default 255, giving the maximum number of consecutive data-memory wait cycles before error.
- REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the statistics counters.
- REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
- REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
- REQ-005 The block SHALL have ports IF_ID_RegisterRs1 and IF_ID_RegisterRs2, input, 5 bits each: source registers of the instruction in decode.
- REQ-006 The block SHALL have port ID_EX_RegisterRd, input, 5 bits: destination register of the instruction in execute.
- REQ-007 The block SHALL have port ID_EX_MemRead, input, 1 bit: the execute-stage instruction is a load.
- REQ-008 The block SHALL have port EX_MEM_BranchTaken, input, 1 bit: a taken branch or jump has resolved in the memory stage.
- REQ-009 The block SHALL have ports dmem_req and dmem_ready, input, 1 bit each: a data access is pending in the memory stage, and the memory completes it this cycle.
- REQ-010 The block SHALL have ports pc_write, IF_ID_write, ID_EX_write and EX_MEM_write, output, 1 bit each: register enables for the PC and the pipeline registers.
- REQ-011 The block SHALL have port ID_EX_bubble, output, 1 bit: load zeros into the ID/EX control fields.
- REQ-012 The block SHALL have ports IF_ID_flush, ID_EX_flush and EX_MEM_flush, output, 1 bit each: squash those stages.
- REQ-013 The block SHALL have port MEM_WB_bubble, output, 1 bit: insert a no-op into MEM/WB.
- REQ-014 The block SHALL have port mem_timeout, output, 1 bit: sticky error flag.
- REQ-015 The block SHALL have ports stall_cycles and flush_count, output, CNT_W bits each: saturating statistics counters.

Function
- REQ-016 The block SHALL implement three states: RUN, MEM_WAIT and ERROR.
- REQ-017 The block SHALL define mem_wait = dmem_req AND NOT dmem_ready.
- REQ-018 The block SHALL define load_use = ID_EX_MemRead AND ID_EX_RegisterRd != 0 AND (ID_EX_RegisterRd == IF_ID_RegisterRs1 OR ID_EX_RegisterRd == IF_ID_RegisterRs2).
- REQ-019 Outputs SHALL be Mealy (current state plus inputs, same cycle); the default is all write enables 1 and all bubble, flush and error outputs 0.
- REQ-020 Freeze SHALL mean pc_write, IF_ID_write, ID_EX_write and EX_MEM_write all 0, MEM_WB_bubble 1, and all flushes and ID_EX_bubble 0.
- REQ-021 In RUN, mem_wait SHALL cause a freeze this cycle, next state MEM_WAIT and wait_cnt set to 1; it has the highest priority.
- REQ-022 In RUN with no mem_wait, EX_MEM_BranchTaken SHALL assert IF_ID_flush, ID_EX_flush and EX_MEM_flush for one cycle; load_use is ignored that cycle.
- REQ-023 In RUN with no mem_wait and no branch, load_use SHALL set pc_write 0, IF_ID_write 0 and ID_EX_bubble 1 for that cycle only, giving a 1-cycle stall; the state stays RUN.
- REQ-024 In MEM_WAIT with dmem_ready 0, the block SHALL freeze and increment wait_cnt.
- REQ-025 In MEM_WAIT, when wait_cnt == TIMEOUT and dmem_ready is 0, the next state SHALL be ERROR.
- REQ-026 In MEM_WAIT with dmem_ready 1, the block SHALL stop freezing, apply the RUN branch/load_use rules in the same cycle, and move to RUN with wait_cnt cleared.
- REQ-027 A branch resolving while frozen SHALL be held by the frozen EX/MEM register and flushed on the release cycle; no branch is lost.
- REQ-028 In ERROR, the block SHALL freeze permanently, assert mem_timeout 1, and leave only via reset.
- REQ-029 wait_cnt SHALL be 8 bits wide, or clog2(TIMEOUT+1) bits when wider, and SHALL never wrap.
- REQ-030 stall_cycles SHALL increment in each cycle where pc_write is 0, saturating at all-ones.
- REQ-031 flush_count SHALL increment in each cycle where IF_ID_flush is 1, saturating at all-ones.

Reset
- REQ-032 While rst is 0, the block SHALL asynchronously force state RUN, wait_cnt 0, stall_cycles 0, flush_count 0 and mem_timeout 0.
- REQ-033 During reset, combinational outputs SHALL show RUN defaults (write enables 1, flushes 0).
- REQ-034 Reset asserted in MEM_WAIT or ERROR SHALL return the block to RUN immediately; the first edge after release SHALL evaluate RUN rules.

Verification
- REQ-035 Load-use: ID_EX_MemRead=1, ID_EX_RegisterRd=5, IF_ID_RegisterRs2=5 -> one cycle with pc_write=0, IF_ID_write=0, ID_EX_bubble=1; stall_cycles goes 0->1.
- REQ-036 Rd zero: same as REQ-035 with ID_EX_RegisterRd=0 and Rs1=0 -> no stall, all writes 1.
- REQ-037 Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> 3 freeze cycles, release on the 4th cycle, state RUN, stall_cycles=3.
- REQ-038 Simultaneous events: mem_wait, branch and load_use all asserted -> freeze only; on the ready cycle the three flushes assert and flush_count=1.
- REQ-039 Timeout: TIMEOUT=4, dmem_ready held 0 -> ERROR entered after 4 wait cycles, mem_timeout=1 and freeze held; rst low -> mem_timeout=0 and state RUN.
- REQ-040 Saturation: CNT_W=4, 20 load-use stalls -> stall_cycles=15, with no wrap.

Source files
------------

// File: rtl/hazard_sched.sv
// hazard_sched: pipeline hazard scheduler covering load-use stalls, branch flushes and data-memory wait/timeout
module hazard_sched #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF_ID_RegisterRs1,
    input  logic [4:0]       IF_ID_RegisterRs2,
    input  logic [4:0]       ID_EX_RegisterRd,
    input  logic             ID_EX_MemRead,
    input  logic             EX_MEM_BranchTaken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             ID_EX_write,
    output logic             EX_MEM_write,
    output logic             ID_EX_bubble,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             EX_MEM_flush,
    output logic             MEM_WB_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    localparam int WCW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [WCW-1:0] W_TO = WCW'(TIMEOUT);
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] ERROR    = 2'd2;

    logic [1:0]       r_state, w_next;
    logic [WCW-1:0]   r_wait_cnt, w_wait_nxt;
    logic [CNT_W-1:0] r_stall, r_flush;
    logic             w_run, w_mem_wait, w_load_use, w_freeze, w_branch, w_stall;

    // Hazard detection and Mealy control outputs; reset shows RUN defaults
    always_comb begin
        w_run        = (r_state != MEM_WAIT) && (r_state != ERROR);
        w_mem_wait   = dmem_req & ~dmem_ready;
        w_load_use   = ID_EX_MemRead && (ID_EX_RegisterRd != 5'd0) &&
                       ((ID_EX_RegisterRd == IF_ID_RegisterRs1) || (ID_EX_RegisterRd == IF_ID_RegisterRs2));
        w_freeze     = rst && ((r_state == ERROR) || (w_run && w_mem_wait) || ((r_state == MEM_WAIT) && !dmem_ready));
        w_branch     = rst && !w_freeze && EX_MEM_BranchTaken;
        w_stall      = rst && !w_freeze && !EX_MEM_BranchTaken && w_load_use;
        pc_write     = !w_freeze && !w_stall;
        IF_ID_write  = !w_freeze && !w_stall;
        ID_EX_write  = !w_freeze;
        EX_MEM_write = !w_freeze;
        ID_EX_bubble = w_stall;
        IF_ID_flush  = w_branch;
        ID_EX_flush  = w_branch;
        EX_MEM_flush = w_branch;
        MEM_WB_bubble = w_freeze;
        mem_timeout  = (r_state == ERROR);
        stall_cycles = r_stall;
        flush_count  = r_flush;
    end

    // Next state and wait counter; the counter saturates rather than wrapping
    always_comb begin
        w_next     = w_run ? (w_mem_wait ? MEM_WAIT : RUN) :
                     (r_state == MEM_WAIT) ? (dmem_ready ? RUN : (r_wait_cnt == W_TO) ? ERROR : MEM_WAIT) :
                     ERROR;
        w_wait_nxt = w_run ? (w_mem_wait ? WCW'(1) : '0) :
                     (r_state == MEM_WAIT) ? (dmem_ready ? '0 : (r_wait_cnt != '1) ? r_wait_cnt + WCW'(1) : r_wait_cnt) :
                     r_wait_cnt;
    end

    // State, wait counter and saturating statistics registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_stall    <= '0;
            r_flush    <= '0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_nxt;
            if (!pc_write && (r_stall != '1)) r_stall <= r_stall + CNT_W'(1);
            if (IF_ID_flush && (r_flush != '1)) r_flush <= r_flush + CNT_W'(1);
        end
    end
endmodule
